overlay_compositor: RTL and testbench

Parametrised per-pixel overlay compositor for the VGA demo pipeline, sitting between the glyph/wave generators and the final background mux. It draws an N-band rainbow trail behind a wave curve using an on-chip per-line history of curve heights, composites N_TEXT text objects with drop shadows, fades text in after reset and can rotate band colours frame by frame. The output is registered.

---
 rtl/overlay_pkg.sv | 42 ++++
 rtl/wave_trail_hist.sv | 76 +++++++
 rtl/overlay_compositor.sv | 189 ++++++++++++++++++
 tb/tb_overlay_compositor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/overlay_pkg.sv
// Shared types and constants for the overlay compositor.
//   rgb6_t        : 6-bit pixel colour {R1R0,G1G0,B1B0}
//   fade_state_t  : text fade FSM states
//   RAINBOW       : trail band palette (r,o,y,g,b,i,v)
//   band_color()  : palette lookup for trail bands k>=1 with rotation phase
package overlay_pkg;

    localparam int unsigned MAX_BANDS = 8;
    localparam int unsigned N_COLORS  = 7;

    typedef logic [5:0] rgb6_t;

    typedef enum logic {
        FADE  = 1'b0,
        SOLID = 1'b1
    } fade_state_t;

    localparam rgb6_t WHITE       = 6'b11_11_11;
    localparam rgb6_t BLACK       = 6'b00_00_00;
    localparam rgb6_t SHADOW_GREY = 6'b01_01_01;

    localparam rgb6_t RAINBOW [N_COLORS] = '{
        6'b11_00_00,  // red
        6'b11_10_00,  // orange
        6'b11_11_00,  // yellow
        6'b00_11_00,  // green
        6'b00_10_11,  // blue
        6'b00_00_11,  // indigo
        6'b10_00_11   // violet
    };

    // Colour of trail band (band >= 1), rotated by phase (0..6).
    function automatic rgb6_t band_color(input logic [2:0] band, input logic [2:0] phase);
        logic [3:0] idx;
        idx = 4'(band) - 4'd1 + 4'(phase);
        if (idx >= 4'(N_COLORS)) begin
            idx = idx - 4'(N_COLORS);
        end
        return RAINBOW[idx[2:0]];
    endfunction

endpackage

// File: rtl/wave_trail_hist.sv
// Per-line history of wave curve rows and per-band hit detection.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   frame_active_i  : visible pixel; history shifts only when high
//   x_i, y_i        : current pixel column / row
//   wave_y_i        : curve row for the current column
//   band_hit_c      : combinational hit per band (band 0 = live curve)
module wave_trail_hist
    import overlay_pkg::*;
#(
    parameter int unsigned N_BANDS = 8,
    parameter int unsigned HALF_T  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_active_i,
    input  logic [9:0]         x_i,
    input  logic [9:0]         y_i,
    input  logic [9:0]         wave_y_i,
    output logic [N_BANDS-1:0] band_hit_c
);

    localparam int unsigned CW    = 10;
    localparam int unsigned DW    = 11;
    // Band k (k>=1) reads entry k-1: entry 0 holds the previous column's curve.
    localparam int unsigned DEPTH = (N_BANDS > 1) ? N_BANDS - 1 : 1;

    logic [CW-1:0]    hist_q [DEPTH];
    logic [CW-1:0]    hist_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic             line_start_c;

    assign line_start_c = frame_active_i && (x_i == '0);

    // |a-b| <= HALF_T with an 11-bit non-wrapping difference
    function automatic logic near(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [DW-1:0] d;
        d = (a >= b) ? (DW'(a) - DW'(b)) : (DW'(b) - DW'(a));
        return d <= DW'(HALF_T);
    endfunction

    // Shift on every visible pixel; a new line restarts the valid chain.
    always_comb begin
        hist_d = hist_q;
        vld_d  = vld_q;
        if (frame_active_i) begin
            hist_d[0] = wave_y_i;
            for (int k = 1; k < int'(DEPTH); k++) begin
                hist_d[k] = hist_q[k-1];
            end
            vld_d = line_start_c ? DEPTH'(1) : DEPTH'({vld_q, 1'b1});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '{default: '0};
            vld_q  <= '0;
        end else begin
            hist_q <= hist_d;
            vld_q  <= vld_d;
        end
    end

    // Stored entries belong to the previous line while x==0, so mask them.
    always_comb begin
        band_hit_c    = '0;
        band_hit_c[0] = frame_active_i && near(y_i, wave_y_i);
        for (int k = 1; k < int'(N_BANDS); k++) begin
            band_hit_c[k] = frame_active_i && !line_start_c && vld_q[k-1]
                            && near(y_i, hist_q[k-1]);
        end
    end

endmodule

// File: rtl/overlay_compositor.sv
// Per-pixel overlay compositor: rainbow wave trail over fading, shadowed text.
// Ports:
//   clk, rst         : pixel clock, synchronous active-high reset
//   x, y             : current pixel column / row
//   frame_active     : visible pixel
//   wave_y           : curve row for column x
//   text_main        : main glyph hit per text object (index 0 highest priority)
//   text_shadow      : shadow glyph hit per text object (offset pre-applied)
//   overlay_rgb      : registered colour {R1R0,G1G0,B1B0}
//   overlay_active   : registered overlay-valid flag
// Optional feature: define OVERLAY_PALETTE_ROTATE_EN to rotate band colours
// every ROT_FRAMES frame ticks; otherwise the rainbow is static.
module overlay_compositor
    import overlay_pkg::*;
#(
    parameter int unsigned N_BANDS     = 8,
    parameter int unsigned N_TEXT      = 3,
    parameter int unsigned HALF_T      = 0,
    parameter int unsigned FADE_FRAMES = 16,
    parameter int unsigned ROT_FRAMES  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              frame_active,
    input  logic [9:0]        wave_y,
    input  logic [N_TEXT-1:0] text_main,
    input  logic [N_TEXT-1:0] text_shadow,
    output logic [5:0]        overlay_rgb,
    output logic              overlay_active
);

    localparam int unsigned FCW = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

    if (N_BANDS < 1 || N_BANDS > MAX_BANDS) begin : g_bad_n_bands
        $error("overlay_compositor: N_BANDS must be 1..8");
    end
    if (N_TEXT < 1) begin : g_bad_n_text
        $error("overlay_compositor: N_TEXT must be >= 1");
    end
    if (FADE_FRAMES < 1) begin : g_bad_fade
        $error("overlay_compositor: FADE_FRAMES must be >= 1");
    end
    if (ROT_FRAMES < 1) begin : g_bad_rot
        $error("overlay_compositor: ROT_FRAMES must be >= 1");
    end

    logic [N_BANDS-1:0] band_hit_c;
    logic               frame_tick_c;
    logic [2:0]         phase_c;

    fade_state_t        state_q, state_d;
    logic [1:0]         level_q, level_d;
    logic [FCW-1:0]     fade_cnt_q, fade_cnt_d;

    rgb6_t              pix_rgb_c;
    logic               pix_active_c;
    rgb6_t              rgb_q;
    logic               active_q;

    wave_trail_hist #(
        .N_BANDS (N_BANDS),
        .HALF_T  (HALF_T)
    ) u_hist (
        .clk            (clk),
        .rst            (rst),
        .frame_active_i (frame_active),
        .x_i            (x),
        .y_i            (y),
        .wave_y_i       (wave_y),
        .band_hit_c     (band_hit_c)
    );

    assign frame_tick_c = frame_active && (x == '0) && (y == '0);

    // Fade FSM: level steps every FADE_FRAMES ticks, locks at SOLID on level 3.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        fade_cnt_d = fade_cnt_q;
        case (state_q)
            FADE: begin
                if (frame_tick_c) begin
                    if (fade_cnt_q == FCW'(FADE_FRAMES - 1)) begin
                        fade_cnt_d = '0;
                        level_d    = level_q + 2'd1;
                        if (level_q == 2'd2) begin
                            state_d = SOLID;
                        end
                    end else begin
                        fade_cnt_d = fade_cnt_q + FCW'(1);
                    end
                end
            end
            SOLID: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FADE;
            level_q    <= 2'd0;
            fade_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            fade_cnt_q <= fade_cnt_d;
        end
    end

`ifdef OVERLAY_PALETTE_ROTATE_EN
    localparam int unsigned RCW = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;

    logic [RCW-1:0] rot_cnt_q, rot_cnt_d;
    logic [2:0]     phase_q, phase_d;

    // Phase advances mod 7 every ROT_FRAMES frame ticks.
    always_comb begin
        rot_cnt_d = rot_cnt_q;
        phase_d   = phase_q;
        if (frame_tick_c) begin
            if (rot_cnt_q == RCW'(ROT_FRAMES - 1)) begin
                rot_cnt_d = '0;
                phase_d   = (phase_q == 3'd6) ? 3'd0 : phase_q + 3'd1;
            end else begin
                rot_cnt_d = rot_cnt_q + RCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rot_cnt_q <= '0;
            phase_q   <= 3'd0;
        end else begin
            rot_cnt_q <= rot_cnt_d;
            phase_q   <= phase_d;
        end
    end

    assign phase_c = phase_q;
`else
    assign phase_c = 3'd0;
`endif

    // Priority: lowest hitting band, else lowest text object (main over shadow).
    // Loops run high-to-low so the lowest index is written last and wins.
    always_comb begin
        pix_rgb_c    = BLACK;
        pix_active_c = 1'b0;
        if (frame_active) begin
            for (int i = int'(N_TEXT) - 1; i >= 0; i--) begin
                if (text_main[i]) begin
                    pix_rgb_c    = {level_q, level_q, level_q};
                    pix_active_c = 1'b1;
                end else if (text_shadow[i]) begin
                    pix_rgb_c    = (level_q >= 2'd2) ? SHADOW_GREY : BLACK;
                    pix_active_c = 1'b1;
                end
            end
            for (int k = int'(N_BANDS) - 1; k >= 1; k--) begin
                if (band_hit_c[k]) begin
                    pix_rgb_c    = band_color(3'(k), phase_c);
                    pix_active_c = 1'b1;
                end
            end
            if (band_hit_c[0]) begin
                pix_rgb_c    = WHITE;
                pix_active_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q    <= BLACK;
            active_q <= 1'b0;
        end else begin
            rgb_q    <= pix_rgb_c;
            active_q <= pix_active_c;
        end
    end

    assign overlay_rgb    = rgb_q;
    assign overlay_active = active_q;

endmodule

// File: tb/tb_overlay_compositor.sv
// Scoreboard bench for overlay_compositor with a queue-based reference model.
module tb_overlay_compositor;

    localparam int NB = 8;
    localparam int NT = 3;
    localparam int HT = 1;
    localparam int FF = 2;
    localparam int RF = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    x, y, wave_y;
    logic          frame_active;
    logic [NT-1:0] text_main, text_shadow;
    logic [5:0]    overlay_rgb;
    logic          overlay_active;

    always #5 clk = ~clk;

    overlay_compositor #(
        .N_BANDS     (NB),
        .N_TEXT      (NT),
        .HALF_T      (HT),
        .FADE_FRAMES (FF),
        .ROT_FRAMES  (RF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .x              (x),
        .y              (y),
        .frame_active   (frame_active),
        .wave_y         (wave_y),
        .text_main      (text_main),
        .text_shadow    (text_shadow),
        .overlay_rgb    (overlay_rgb),
        .overlay_active (overlay_active)
    );

    typedef struct {
        logic [5:0] rgb;
        logic       act;
        int         id;
    } exp_t;

    exp_t       sb[$];
    int         trail[$];   // curve rows of earlier columns on this line, newest first
    int         ticks;      // frame ticks since reset
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_pix = 0;
    logic [5:0] rb [7];

    initial begin
        rb[0] = 6'b11_00_00; rb[1] = 6'b11_10_00; rb[2] = 6'b11_11_00;
        rb[3] = 6'b00_11_00; rb[4] = 6'b00_10_11; rb[5] = 6'b00_00_11;
        rb[6] = 6'b10_00_11;
    end

    // Drive one pixel, predict its output, and advance the model.
    task automatic cyc(input bit r, input bit fa, input int xi, input int yi, input int wi,
                       input logic [NT-1:0] tm, input logic [NT-1:0] ts);
        exp_t e;
        bit   found;
        int   val, lvl, ph, d;
        @(negedge clk);
        rst = r; frame_active = fa;
        x = 10'(xi); y = 10'(yi); wave_y = 10'(wi);
        text_main = tm; text_shadow = ts;
        e.rgb = 6'd0; e.act = 1'b0; e.id = n_pix;
        lvl = (ticks / FF > 3) ? 3 : ticks / FF;
`ifdef OVERLAY_PALETTE_ROTATE_EN
        ph = (ticks / RF) % 7;
`else
        ph = 0;
`endif
        if (!r && fa) begin
            found = 1'b0;
            for (int k = 0; k < NB && !found; k++) begin
                if (k == 0) val = wi;
                else if (xi != 0 && trail.size() >= k) val = trail[k-1];
                else continue;
                d = (yi > val) ? yi - val : val - yi;
                if (d <= HT) begin
                    found = 1'b1; e.act = 1'b1;
                    e.rgb = (k == 0) ? 6'b11_11_11 : rb[(k - 1 + ph) % 7];
                end
            end
            for (int i = 0; i < NT && !found; i++) begin
                if (tm[i]) begin
                    found = 1'b1; e.act = 1'b1; e.rgb = {3{2'(lvl)}};
                end else if (ts[i]) begin
                    found = 1'b1; e.act = 1'b1; e.rgb = (lvl >= 2) ? 6'b01_01_01 : 6'b00_00_00;
                end
            end
        end
        sb.push_back(e);
        n_pix++;
        if (r) begin
            trail.delete();
            ticks = 0;
        end else if (fa) begin
            if (xi == 0) trail.delete();
            trail.push_front(wi);
            if (trail.size() > NB) void'(trail.pop_back());
            if (xi == 0 && yi == 0) ticks++;
        end
    endtask

    // Monitor: one registered output per issued pixel.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if ({overlay_rgb, overlay_active} !== {e.rgb, e.act}) begin
                    n_err++;
                    $display("FAIL pixel%0d: got rgb=%b act=%b, expected rgb=%b act=%b",
                             e.id, overlay_rgb, overlay_active, e.rgb, e.act);
                end
            end
        end
    end

    function automatic int near_wave(input int yi);
        int w;
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 1023));
        w = yi + int'($urandom_range(0, 6)) - 3;
        if (w < 0) w = 1023;       // far in magnitude, adjacent if differences wrapped
        if (w > 1023) w = 0;
        return w;
    endfunction

    initial begin
        int yv, xi;
        logic [NT-1:0] tm, ts;
        rst = 1'b1; frame_active = 1'b0; x = '0; y = '0; wave_y = '0;
        text_main = '0; text_shadow = '0;
        ticks = 0;

        repeat (3) cyc(1, 0, 0, 0, 0, 3'b000, 3'b000);

        // Constant trail row
        for (int i = 0; i < 6; i++) cyc(0, 1, i, 100, 100, 3'b000, 3'b000);
        // Kink at x=10: bands step through the rainbow, then run out
        for (int i = 0; i < 20; i++) cyc(0, 1, i, 100, (i < 10) ? 100 : 200, 3'b000, 3'b000);

        // Fade ramp: text object 1 on every pixel, several frames
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 4; i++) cyc(0, 1, i, 0, 900, 3'b010, 3'b000);
            cyc(0, 0, 0, 0, 0, 3'b010, 3'b000);
        end
        // Shadow of object 0 beats main of object 2; then add a band hit
        cyc(0, 1, 0, 50, 900, 3'b100, 3'b001);
        cyc(0, 1, 1, 50, 900, 3'b100, 3'b001);
        cyc(0, 1, 2, 50, 50,  3'b100, 3'b001);
        cyc(0, 1, 3, 50, 900, 3'b100, 3'b001);

        // Randomized frames with blanking, mid-line stalls and rare resets
        for (int f = 0; f < 40; f++) begin
            for (int l = 0; l < 3; l++) begin
                yv = (l == 0) ? 0 : int'($urandom_range(0, 1023));
                if ($urandom_range(0, 4) == 0) yv = int'($urandom_range(0, 2));
                xi = 0;
                while (xi < 20) begin
                    tm = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
                    ts = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
                    if ($urandom_range(0, 15) == 0) begin
                        cyc(0, 0, xi, yv, int'($urandom_range(0, 1023)), tm, ts);
                    end else if ($urandom_range(0, 199) == 0) begin
                        cyc(1, 1, xi, yv, near_wave(yv), tm, ts);
                        xi++;
                    end else begin
                        cyc(0, 1, xi, yv, near_wave(yv), tm, ts);
                        xi++;
                    end
                end
                for (int b = 0; b < 2; b++)
                    cyc(0, 0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                        int'($urandom_range(0, 1023)), 3'b111, 3'b111);
            end
        end

        // Mid-line reset at x=300; the trail must restart empty
        for (int i = 0; i < 311; i++) cyc(i == 300, 1, i, 5, 5, 3'b000, 3'b000);

        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected outputs left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
